// File: rtl/bios_loader.sv
// bios_loader: copies a block of HD words into instruction memory while holding
// the processor, then releases it and forwards the PC as the fetch address.
module bios_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [31:0]           StartAddr,
  input  logic [ADDR_WIDTH:0]   Length,
  input  logic [31:0]           PCAddr,
  input  logic [WORD_WIDTH-1:0] HDData,
  output logic [31:0]           HDAddr,
  output logic [ADDR_WIDTH-1:0] IMAddr,
  output logic [WORD_WIDTH-1:0] IMData,
  output logic                  IMWrite,
  output logic                  CPUHold,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH:0]   WordCount
);

  localparam logic [ADDR_WIDTH:0]   MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   One    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] OneA   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {StBootIdle, StLoad, StFlush, StDone, StRun} state_e;

  state_e               state_q, state_d;
  logic [31:0]          hd_addr_q;
  logic [ADDR_WIDTH:0]  len_q;
  logic [ADDR_WIDTH:0]  idx_q;
  logic [ADDR_WIDTH:0]  wc_q;
  logic                 start_ok;
  logic                 more_issue;
  logic [ADDR_WIDTH:0]  len_clamp;
  logic                 unused_pc;

  assign start_ok   = Start && (state_q == StBootIdle || state_q == StRun);
  assign len_clamp  = (Length > MaxLen) ? MaxLen : Length;
  // Another HD read remains to be issued after the current index.
  assign more_issue = (idx_q < (len_q - One));
  // Only the low PC bits address instruction memory.
  assign unused_pc  = ^PCAddr[31:ADDR_WIDTH];

  assign HDAddr    = hd_addr_q;
  assign WordCount = wc_q;

  // State register with synchronous reset; reset aborts any load in flight.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= StBootIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBootIdle, StRun: begin
        if (start_ok) state_d = (len_clamp == '0) ? StDone : StLoad;
      end
      StLoad:  if (!more_issue) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StBootIdle;
    endcase
  end

  // Load datapath: latch request, step HD read address and issue index, count writes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hd_addr_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wc_q      <= '0;
    end else if (start_ok) begin
      hd_addr_q <= StartAddr;
      len_q     <= len_clamp;
      idx_q     <= '0;
      wc_q      <= '0;
    end else if (state_q == StLoad) begin
      // Index 0 only issues a read; every later LOAD cycle also writes a word.
      if (idx_q != '0) wc_q <= wc_q + One;
      if (more_issue) begin
        hd_addr_q <= hd_addr_q + 32'd1;
        idx_q     <= idx_q + One;
      end
    end else if (state_q == StFlush) begin
      wc_q <= wc_q + One;
    end
  end

  // Outputs decoded from state; HD data lags its address by one cycle.
  always_comb begin
    IMWrite = 1'b0;
    IMAddr  = '0;
    IMData  = '0;
    CPUHold = 1'b1;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      StLoad: begin
        Busy = 1'b1;
        if (idx_q != '0) begin
          IMWrite = 1'b1;
          IMAddr  = idx_q[ADDR_WIDTH-1:0] - OneA;
          IMData  = HDData;
        end
      end
      StFlush: begin
        Busy    = 1'b1;
        IMWrite = 1'b1;
        IMAddr  = len_q[ADDR_WIDTH-1:0] - OneA;
        IMData  = HDData;
      end
      StDone: Done = 1'b1;
      StRun: begin
        CPUHold = 1'b0;
        IMAddr  = PCAddr[ADDR_WIDTH-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bios_loader.md
Name: bios_loader

Overview:
- Boot/program loader sitting directly upstream of the processor's instruction port.
- On a Start request, copies a block of words from the simulated HD into instruction memory while holding the processor.
- Afterwards it releases the processor and passes the processor's PC through as the instruction-memory address.
- Used at power-up (BIOS load) and on every process reload by the OS.

Parameters:
- ADDR_WIDTH, 10, instruction-memory address width; capacity 2^ADDR_WIDTH words.
- WORD_WIDTH, 32, instruction and HD word width.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  load request; sampled only in BOOT_IDLE or RUN.
- StartAddr  in  32  first HD word address of the program block.
- Length  in  ADDR_WIDTH+1  number of words to copy.
- PCAddr  in  32  processor PC (Endereco), used as the fetch address in RUN.
- HDData  in  WORD_WIDTH  HD read data; synchronous read, valid the cycle after HDAddr.
- HDAddr  out  32  registered HD read address.
- IMAddr  out  ADDR_WIDTH  instruction-memory address (write or fetch).
- IMData  out  WORD_WIDTH  instruction-memory write data.
- IMWrite  out  1  instruction-memory write enable.
- CPUHold  out  1  drives the processor Halt/hold input.
- Busy  out  1  high in LOAD and FLUSH.
- Done  out  1  one-cycle completion pulse.
- WordCount  out  ADDR_WIDTH+1  words written so far in the current load.

Behaviour:
- States and outputs:
  - BOOT_IDLE: CPUHold=1, IMWrite=0.
  - LOAD: issue HD reads and write the previously read word; Busy=1.
  - FLUSH: write the final word; Busy=1.
  - DONE: Done=1, CPUHold=1, IMWrite=0; lasts one cycle.
  - RUN: CPUHold=0, IMAddr=PCAddr[ADDR_WIDTH-1:0], IMWrite=0.
- Reset, applied in any state including mid-load: next state BOOT_IDLE.
  - HDAddr=0, IMAddr=0, IMData=0, IMWrite=0, CPUHold=1, Busy=0, Done=0, WordCount=0.
  - A load aborted by Reset leaves partially written memory. No completion pulse is issued.
- Start in BOOT_IDLE or RUN:
  - StartAddr and Length are latched; Length is clamped to 2^ADDR_WIDTH.
  - Latched length 0: go to DONE next cycle.
  - Otherwise: go to LOAD next cycle with HDAddr=StartAddr and issue index i=0. CPUHold rises in the same cycle LOAD is entered.
- LOAD, each cycle:
  - If i>=1: IMWrite=1, IMAddr=i-1, IMData=HDData, WordCount increments.
  - If i < Length-1: HDAddr<=StartAddr+i+1, i increments.
  - Otherwise: go to FLUSH.
- FLUSH: IMWrite=1, IMAddr=Length-1, IMData=HDData, WordCount increments; next state DONE.
- DONE: next state RUN. WordCount holds its final value until the next Start or Reset.
- Throughput and latency: one word per cycle. Length>=1 takes Length+1 cycles from the first LOAD cycle to DONE entry. IMWrite is high for exactly Length cycles.
- Arithmetic: HDAddr arithmetic is modulo 2^32 (wraps without error). IM write index never exceeds 2^ADDR_WIDTH-1 because of the clamp.
- Start while Busy or in DONE is ignored and not queued.
- Start with Length=0 in RUN: CPUHold=1 for exactly the DONE cycle, then RUN resumes.
- IMWrite and the RUN fetch mux are mutually exclusive. IMAddr only follows PCAddr in RUN.

Test Plan:
- Reset, then Start with StartAddr=100, Length=4, HD[100..103]=A0..A3:
  - IMWrite high for 4 consecutive cycles writing IM[0..3]=A0..A3.
  - Done pulses 1 cycle, 5 cycles after LOAD entry.
  - CPUHold falls the following cycle; WordCount=4.
- Length=1, StartAddr=7: LOAD→FLUSH→DONE→RUN; single write IM[0]=HD[7].
- Length=0 from BOOT_IDLE: no IMWrite; Done pulses the cycle after Start; then RUN.
- In RUN with PCAddr=0x0000_0405: IMAddr=0x005, IMWrite=0, CPUHold=0.
  - New Start with Length=2 reasserts CPUHold and reloads IM[0..1].
- StartAddr=0xFFFF_FFFE, Length=3: HDAddr sequence FFFF_FFFE, FFFF_FFFF, 0000_0000. IM[0..2] loaded.
- Length=2000 (above 1024): clamped to 1024 writes.
  - Start pulsed again mid-load is ignored.
  - Reset at write 500: IMWrite=0 and state BOOT_IDLE next cycle; no Done pulse.
